uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx_cfg.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART receiver shared types.
//   parity_e   : parity mode selection for the receiver
//   rx_state_e : receive FSM state encoding
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Line synchronizer: three-flop chain on the asynchronous UART input
// followed by a 2-of-3 majority vote across the chain, which also
// rejects single-cycle spikes on the line.
//   i_clk       : system clock
//   i_rst_n     : asynchronous reset, active low (flops preset to idle-high)
//   i_rx_serial : raw UART line
//   o_rx        : synchronized, voted line level
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx_serial,
    output logic o_rx
);

    logic [2:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], i_rx_serial};
        end
    end

    assign o_rx = (sync_q[0] & sync_q[1]) | (sync_q[0] & sync_q[2]) | (sync_q[1] & sync_q[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with a single-word holding register.
//   i_clk        : system clock
//   i_rst_n      : asynchronous reset, active low
//   i_rx_serial  : UART line, idle high
//   i_rx_ready   : consumer ready; word accepted when o_rx_valid & i_rx_ready
//   i_clr_err    : pulse clearing o_overrun
//   o_rx_valid   : holding register contains an unaccepted word
//   o_rx_data    : received word, bit 0 received first
//   o_parity_err : parity mismatch for o_rx_data (qualified by o_rx_valid)
//   o_frame_err  : a stop bit sampled low (qualified by o_rx_valid)
//   o_break      : one-cycle pulse on break detection
//   o_overrun    : sticky, a completed frame was dropped
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | line idle, waiting for a falling edge
// ST_START     | inside start bit, mid-sample rejects false starts
// ST_DATA      | shifting data bits LSB first
// ST_PARITY    | sampling the parity bit
// ST_STOP      | sampling stop bit(s); frame completes at last mid-sample
// ST_WAIT_IDLE | line held low (break or bad stop), wait for it to rise
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int      CLKS_PER_BIT = 434,
    parameter int      DATA_BITS    = 8,
    parameter parity_e PARITY       = PAR_NONE,
    parameter int      STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_serial,
    input  logic                 i_rx_ready,
    input  logic                 i_clr_err,
    output logic                 o_rx_valid,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_overrun
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic                 rx;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 fe_q;

    logic mid, bit_end, frame_done, brk_evt, is_break, par_err, frame_err;

    uart_rx_sync u_sync (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rx_serial (i_rx_serial),
        .o_rx        (rx)
    );

    assign mid     = (clk_cnt == CW'(HALF));
    assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    // Break only counts when every bit up to and including the first stop is low.
    assign is_break = (shift_q == '0) && ((PARITY == PAR_NONE) || !par_q) && !rx;

    always_comb begin
        par_err = 1'b0;
        if (PARITY == PAR_EVEN) par_err = ^{shift_q, par_q};
        if (PARITY == PAR_ODD)  par_err = ~(^{shift_q, par_q});
    end

    assign frame_err = fe_q | ~rx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        brk_evt    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx) state_d = ST_START;
            end
            ST_START: begin
                if (mid && rx)    state_d = ST_IDLE;
                else if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_idx == BW'(DATA_BITS)))
                    state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (mid) begin
                    if ((bit_idx == '0) && is_break) begin
                        brk_evt = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end else if (bit_idx == BW'(STOP_BITS - 1)) begin
                        frame_done = 1'b1;
                        state_d    = rx ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rx) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bit timing and frame datapath. Counters rest at zero while idle so
    // they start from zero on entry to ST_START.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else if ((state_q == ST_IDLE) || (state_q == ST_WAIT_IDLE)) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            fe_q    <= 1'b0;
        end else begin
            clk_cnt <= bit_end ? '0 : clk_cnt + CW'(1);
            if ((state_q == ST_DATA) && mid) begin
                shift_q <= {rx, shift_q[DATA_BITS-1:1]};
                bit_idx <= bit_idx + BW'(1);
            end
            if ((state_q == ST_DATA) && bit_end && (bit_idx == BW'(DATA_BITS)))
                bit_idx <= '0;
            if ((state_q == ST_PARITY) && mid)
                par_q <= rx;
            if ((state_q == ST_STOP) && mid) begin
                fe_q    <= fe_q | ~rx;
                bit_idx <= bit_idx + BW'(1);
            end
        end
    end

    // Holding register: a completion may load only when the slot is free or
    // being emptied this same cycle; otherwise the new frame is dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_valid   <= 1'b0;
            o_rx_data    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_break <= brk_evt;
            if (frame_done && (!o_rx_valid || i_rx_ready)) begin
                o_rx_valid   <= 1'b1;
                o_rx_data    <= shift_q;
                o_parity_err <= par_err;
                o_frame_err  <= frame_err;
                if (i_clr_err) o_overrun <= 1'b0;
            end else if (frame_done) begin
                o_overrun <= 1'b1;
            end else begin
                if (o_rx_valid && i_rx_ready) o_rx_valid <= 1'b0;
                if (i_clr_err) o_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       rx_a, rdy_a, clr_a, valid_a, perr_a, ferr_a, brk_a, ovr_a;
    logic [7:0] data_a;
    logic       rx_b, rdy_b, clr_b, valid_b, perr_b, ferr_b, brk_b, ovr_b;
    logic [6:0] data_b;

    int n_checks = 0;
    int n_fail   = 0;

    int acc_a = 0, vcyc_a = 0, brk_cnt_a = 0, acc_b = 0;
    logic [7:0] last_a = '0;
    logic       last_pe_a = 1'b0, last_fe_a = 1'b0;
    logic [6:0] last_b = '0;
    logic       last_pe_b = 1'b0, last_fe_b = 1'b0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_8n1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx_a), .i_rx_ready(rdy_a), .i_clr_err(clr_a),
        .o_rx_valid(valid_a), .o_rx_data(data_a), .o_parity_err(perr_a), .o_frame_err(ferr_a),
        .o_break(brk_a), .o_overrun(ovr_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2)) dut_7e2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx_b), .i_rx_ready(rdy_b), .i_clr_err(clr_b),
        .o_rx_valid(valid_b), .o_rx_data(data_b), .o_parity_err(perr_b), .o_frame_err(ferr_b),
        .o_break(brk_b), .o_overrun(ovr_b)
    );

    // Record accepted words, valid-high cycles and break pulses.
    always @(negedge clk) begin
        if (valid_a) vcyc_a <= vcyc_a + 1;
        if (brk_a) brk_cnt_a <= brk_cnt_a + 1;
        if (valid_a && rdy_a) begin
            acc_a     <= acc_a + 1;
            last_a    <= data_a;
            last_pe_a <= perr_a;
            last_fe_a <= ferr_a;
        end
        if (valid_b && rdy_b) begin
            acc_b     <= acc_b + 1;
            last_b    <= data_b;
            last_pe_b <= perr_b;
            last_fe_b <= ferr_b;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input int sel, input logic b);
        if (sel == 0) rx_a = b;
        else          rx_b = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Bits go out LSB first: bits[0] is the start bit.
    task automatic send_frame(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(sel, bits[i]);
    endtask

    int a0, v0, b0, c0;
    logic [7:0] byte_5a;

    initial begin
        rx_a = 1'b1; rdy_a = 1'b1; clr_a = 1'b0;
        rx_b = 1'b1; rdy_b = 1'b1; clr_b = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_valid_a", {31'd0, valid_a}, 0);
        check_eq("rst_data_a", {24'd0, data_a}, 0);
        check_eq("rst_perr_a", {31'd0, perr_a}, 0);
        check_eq("rst_ferr_a", {31'd0, ferr_a}, 0);
        check_eq("rst_brk_a", {31'd0, brk_a}, 0);
        check_eq("rst_ovr_a", {31'd0, ovr_a}, 0);
        check_eq("rst_valid_b", {31'd0, valid_b}, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 8N1 0xA5, consumer always ready
        a0 = acc_a; v0 = vcyc_a;
        send_frame(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10);
        repeat (CPB) @(negedge clk);
        check_eq("a5_count", acc_a - a0, 1);
        check_eq("a5_data", {24'd0, last_a}, 32'hA5);
        check_eq("a5_perr", {31'd0, last_pe_a}, 0);
        check_eq("a5_ferr", {31'd0, last_fe_a}, 0);
        check_eq("a5_valid_cycles", vcyc_a - v0, 1);
        check_eq("a5_ovr", {31'd0, ovr_a}, 0);

        // 7E2 0x35 (four ones): parity bit 1 is wrong, second stop bit low
        c0 = acc_b;
        send_frame(1, {4'd0, 1'b0, 1'b1, 1'b1, 7'h35, 1'b0}, 11);
        send_bit(1, 1'b1);
        send_bit(1, 1'b1);
        check_eq("7e2_bad_data", {25'd0, last_b}, 32'h35);
        check_eq("7e2_bad_perr", {31'd0, last_pe_b}, 1);
        check_eq("7e2_bad_ferr", {31'd0, last_fe_b}, 1);
        // 7E2 0x2A (three ones): parity bit 1 is correct, both stops high
        send_frame(1, {4'd0, 1'b1, 1'b1, 1'b1, 7'h2A, 1'b0}, 11);
        send_bit(1, 1'b1);
        check_eq("7e2_good_data", {25'd0, last_b}, 32'h2A);
        check_eq("7e2_good_perr", {31'd0, last_pe_b}, 0);
        check_eq("7e2_good_ferr", {31'd0, last_fe_b}, 0);
        check_eq("7e2_count", acc_b - c0, 2);

        // Break: start, data and stop all low, so hold the line low well past the stop bit
        a0 = acc_a; v0 = vcyc_a; b0 = brk_cnt_a;
        rx_a = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check_eq("brk_pulses", brk_cnt_a - b0, 1);
        check_eq("brk_no_word", acc_a - a0, 0);
        check_eq("brk_no_valid", vcyc_a - v0, 0);
        rx_a = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_eq("brk_after_release", brk_cnt_a - b0, 1);
        check_eq("brk_after_valid", vcyc_a - v0, 0);

        // Overrun: consumer stalled, second frame dropped
        rdy_a = 1'b0;
        send_frame(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10);
        send_bit(0, 1'b1);
        check_eq("ovr_first_valid", {31'd0, valid_a}, 1);
        check_eq("ovr_first_flag", {31'd0, ovr_a}, 0);
        send_frame(0, {6'd0, 1'b1, 8'h22, 1'b0}, 10);
        send_bit(0, 1'b1);
        check_eq("ovr_held_data", {24'd0, data_a}, 32'h11);
        check_eq("ovr_flag", {31'd0, ovr_a}, 1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        @(negedge clk);
        check_eq("ovr_cleared", {31'd0, ovr_a}, 0);
        check_eq("ovr_data_stable", {24'd0, data_a}, 32'h11);
        rdy_a = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("ovr_accepted", {24'd0, last_a}, 32'h11);
        check_eq("ovr_valid_drop", {31'd0, valid_a}, 0);

        // 4-clock glitch is a false start
        a0 = acc_a; b0 = brk_cnt_a;
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_eq("glitch_no_word", acc_a - a0, 0);
        check_eq("glitch_valid", {31'd0, valid_a}, 0);
        check_eq("glitch_no_brk", brk_cnt_a - b0, 0);

        // Reset in the middle of data bit 3; o_rx_data still holds 0x11 beforehand
        byte_5a = 8'h5A;
        a0 = acc_a;
        send_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, byte_5a[i]);
        rx_a = byte_5a[3];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midrst_valid", {31'd0, valid_a}, 0);
        check_eq("midrst_data", {24'd0, data_a}, 0);
        check_eq("midrst_perr", {31'd0, perr_a}, 0);
        check_eq("midrst_ferr", {31'd0, ferr_a}, 0);
        check_eq("midrst_ovr", {31'd0, ovr_a}, 0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_eq("midrst_no_word", acc_a - a0, 0);
        send_frame(0, {6'd0, 1'b1, 8'h5A, 1'b0}, 10);
        send_bit(0, 1'b1);
        check_eq("post_rst_count", acc_a - a0, 1);
        check_eq("post_rst_data", {24'd0, last_a}, 32'h5A);
        check_eq("post_rst_ferr", {31'd0, last_fe_a}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
